// File: rtl/approx_or_adder_pipe.sv
// ---------------------------------------------------------------------------
// approx_or_adder_pipe
//
// Two-stage pipelined LSB OR-approximate adder with on-chip error statistics.
// The low APPROX_LSBS result bits are the bitwise OR of the operands. The
// upper bits are an exact add, fed by the carry that the top approximated
// bit pair would have produced. A per-transaction mode bit selects a fully
// exact add instead. An exact reference sum is computed alongside every
// result, and the absolute error is reported and accumulated.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   A, B, Cin           operands and carry-in
//   mode_exact          1 = exact add for this transaction
//   out_valid/out_ready output handshake
//   S, Cout             result sum and carry-out
//   err_dist            |exact - {Cout,S}| for the presented result
//   stats_clr           synchronous clear of the statistics
//   n_samples           transferred outputs (saturating)
//   n_errors            transferred outputs with non-zero error (saturating)
//   max_err             largest transferred error
//   sum_err             sum of transferred errors (saturating)
// ---------------------------------------------------------------------------
module approx_or_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_LSBS = 2,
    parameter int CNT_W       = 32,
    parameter int SUM_W       = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             mode_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH:0]   err_dist,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] n_errors,
    output logic [WIDTH:0]   max_err,
    output logic [SUM_W-1:0] sum_err
);

    localparam int K  = APPROX_LSBS;
    localparam int EW = WIDTH + 1;
    // Accumulator add is done one bit wider than the larger operand so that
    // overflow past SUM_W is visible and can be clamped.
    localparam int AW = ((SUM_W > EW) ? SUM_W : EW) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    SUM_LIM = AW'({SUM_W{1'b1}});

    // -----------------------------------------------------------------------
    // Handshake enables
    // -----------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic en1, en2;

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // -----------------------------------------------------------------------
    // Stage 1: operand register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic             cin1_q, cin1_d;
    logic             mode1_q, mode1_d;

    always_comb begin
        v1_d    = v1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        cin1_d  = cin1_q;
        mode1_d = mode1_q;
        if (en1) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1_d    = A;
                b1_d    = B;
                cin1_d  = Cin;
                mode1_d = mode_exact;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            cin1_q  <= 1'b0;
            mode1_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            cin1_q  <= cin1_d;
            mode1_q <= mode1_d;
        end
    end

    // -----------------------------------------------------------------------
    // Arithmetic on the stage-1 operands
    // -----------------------------------------------------------------------
    logic [EW-1:0] exact_sum;
    logic [EW-1:0] approx_sum;
    logic [EW-1:0] res_sum;
    logic [EW-1:0] diff;

    assign exact_sum = {1'b0, a1_q} + {1'b0, b1_q} + {{WIDTH{1'b0}}, cin1_q};

    genvar gi;
    generate
        if (K == 0) begin : g_exact_only
            assign approx_sum = exact_sum;
        end else if (K >= WIDTH) begin : g_all_or
            logic [WIDTH-1:0] or_bits;
            for (gi = 0; gi < WIDTH; gi++) begin : g_or
                assign or_bits[gi] = a1_q[gi] | b1_q[gi];
            end
            // No exact upper part remains; the carry-out is the carry the
            // MSB pair would have generated on its own.
            assign approx_sum = {a1_q[WIDTH-1] & b1_q[WIDTH-1], or_bits};
        end else begin : g_mixed
            localparam int UW = WIDTH - K + 1;
            logic [K-1:0]  or_bits;
            logic          carry_k;
            logic [UW-1:0] upper;
            for (gi = 0; gi < K; gi++) begin : g_or
                assign or_bits[gi] = a1_q[gi] | b1_q[gi];
            end
            // Carry into the exact part comes only from the top OR'd pair;
            // Cin and lower carries are deliberately dropped.
            assign carry_k = a1_q[K-1] & b1_q[K-1];
            assign upper   = {1'b0, a1_q[WIDTH-1:K]} + {1'b0, b1_q[WIDTH-1:K]}
                           + {{(UW-1){1'b0}}, carry_k};
            assign approx_sum = {upper, or_bits};
        end
    endgenerate

    assign res_sum = mode1_q ? exact_sum : approx_sum;
    assign diff    = (exact_sum >= res_sum) ? (exact_sum - res_sum)
                                            : (res_sum - exact_sum);

    // -----------------------------------------------------------------------
    // Stage 2: result register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] s2_q, s2_d;
    logic             cout2_q, cout2_d;
    logic [EW-1:0]    err2_q, err2_d;

    always_comb begin
        v2_d    = v2_q;
        s2_d    = s2_q;
        cout2_d = cout2_q;
        err2_d  = err2_q;
        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d    = res_sum[WIDTH-1:0];
                cout2_d = res_sum[WIDTH];
                err2_d  = diff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            s2_q    <= '0;
            cout2_q <= 1'b0;
            err2_q  <= '0;
        end else begin
            v2_q    <= v2_d;
            s2_q    <= s2_d;
            cout2_q <= cout2_d;
            err2_q  <= err2_d;
        end
    end

    assign out_valid = v2_q;
    assign S         = s2_q;
    assign Cout      = cout2_q;
    assign err_dist  = err2_q;

    // -----------------------------------------------------------------------
    // Error statistics, updated on each output transfer
    // -----------------------------------------------------------------------
    logic             xfer;
    logic [CNT_W-1:0] n_samples_q, n_samples_d;
    logic [CNT_W-1:0] n_errors_q, n_errors_d;
    logic [EW-1:0]    max_err_q, max_err_d;
    logic [SUM_W-1:0] sum_err_q, sum_err_d;
    logic [AW-1:0]    sum_wide;
    logic [SUM_W-1:0] sum_sat;

    assign xfer     = v2_q && out_ready;
    assign sum_wide = AW'(sum_err_q) + AW'(err2_q);
    assign sum_sat  = (sum_wide > SUM_LIM) ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

    always_comb begin
        n_samples_d = n_samples_q;
        n_errors_d  = n_errors_q;
        max_err_d   = max_err_q;
        sum_err_d   = sum_err_q;
        // Clear has priority: a transfer in the same cycle is not counted.
        if (stats_clr) begin
            n_samples_d = '0;
            n_errors_d  = '0;
            max_err_d   = '0;
            sum_err_d   = '0;
        end else if (xfer) begin
            if (n_samples_q != CNT_MAX) begin
                n_samples_d = n_samples_q + CNT_ONE;
            end
            if ((err2_q != '0) && (n_errors_q != CNT_MAX)) begin
                n_errors_d = n_errors_q + CNT_ONE;
            end
            if (err2_q > max_err_q) begin
                max_err_d = err2_q;
            end
            sum_err_d = sum_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_samples_q <= '0;
            n_errors_q  <= '0;
            max_err_q   <= '0;
            sum_err_q   <= '0;
        end else begin
            n_samples_q <= n_samples_d;
            n_errors_q  <= n_errors_d;
            max_err_q   <= max_err_d;
            sum_err_q   <= sum_err_d;
        end
    end

    assign n_samples = n_samples_q;
    assign n_errors  = n_errors_q;
    assign max_err   = max_err_q;
    assign sum_err   = sum_err_q;

endmodule
